// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: M-stage load/store unit for the 5-stage RV32I pipeline.
// It turns the M-stage memory controls into a single request/acknowledge
// transaction on the data bus. The pipeline is stalled until the access
// completes. It also handles byte/halfword lane steering, load extension,
// misalignment detection and bus timeout.
//
// Ports:
//   clk, rst           pipeline clock (rising edge); synchronous active-low reset
//   mem_rd_M/mem_wr_M  load / store in M (both set -> load)
//   mem_mask_M         funct3 size code (B, H, W, BU, HU; 011/110/111 -> W)
//   alu_o_M            effective byte address
//   wr_data_M          store data (rs2)
//   rd_data_M          extended load result
//   stall_M            hold F/D/E/M pipeline registers
//   misalign_M         one-cycle pulse, misaligned access (no bus cycle)
//   fault_M            one-cycle pulse, bus error or timeout
//   bus_*              registered request/ack data-memory bus
module mem_stage_lsu #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_rd_M,
  input  logic        mem_wr_M,
  input  logic [2:0]  mem_mask_M,
  input  logic [31:0] alu_o_M,
  input  logic [31:0] wr_data_M,
  output logic [31:0] rd_data_M,
  output logic        stall_M,
  output logic        misalign_M,
  output logic        fault_M,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  input  logic        bus_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [9:0] TIMEOUT_LIM = 10'(TIMEOUT);

  // Access size codes.
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  state_t      state;
  logic [9:0]  to_cnt;
  logic        fault_q;
  logic [31:0] rd_q;
  logic        ld_q;
  logic        uns_q;
  logic [1:0]  size_q;
  logic [1:0]  off_q;

  logic        access;
  logic        aligned;
  logic [1:0]  size;
  logic [1:0]  off;
  logic [3:0]  be_nxt;
  logic [31:0] wdata_nxt;
  logic [31:0] rdata_sh;
  logic [31:0] ld_ext;
  logic [9:0]  to_cnt_inc;
  logic        timeout_hit;

  // Request decode from the live M-stage controls.
  always_comb begin
    access    = mem_rd_M | mem_wr_M;
    off       = alu_o_M[1:0];
    // funct3[1] set covers 010/011/110/111, all word accesses.
    size      = mem_mask_M[1] ? SZ_W : {1'b0, mem_mask_M[0]};
    aligned   = 1'b1;
    be_nxt    = 4'b1111;
    wdata_nxt = wr_data_M;
    case (size)
      SZ_B: begin
        be_nxt    = 4'b0001 << off;
        wdata_nxt = {4{wr_data_M[7:0]}};
      end
      SZ_H: begin
        aligned   = ~off[0];
        be_nxt    = 4'b0011 << off;
        wdata_nxt = {2{wr_data_M[15:0]}};
      end
      default: begin
        aligned   = (off == 2'b00);
        be_nxt    = 4'b1111;
        wdata_nxt = wr_data_M;
      end
    endcase
  end

  // Load extension uses the size/offset latched at request time.
  always_comb begin
    rdata_sh = bus_rdata >> {off_q, 3'b000};
    case (size_q)
      SZ_B:    ld_ext = uns_q ? {24'h000000, rdata_sh[7:0]}
                              : {{24{rdata_sh[7]}}, rdata_sh[7:0]};
      SZ_H:    ld_ext = uns_q ? {16'h0000, rdata_sh[15:0]}
                              : {{16{rdata_sh[15]}}, rdata_sh[15:0]};
      default: ld_ext = bus_rdata;
    endcase
  end

  // Saturating increment; the limit is compared against the count this
  // REQ cycle will have consumed, so TIMEOUT=N gives N REQ cycles.
  always_comb begin
    to_cnt_inc  = (to_cnt == '1) ? to_cnt : to_cnt + 10'd1;
    timeout_hit = (to_cnt_inc >= TIMEOUT_LIM);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_be    <= '0;
      bus_wdata <= '0;
      rd_q      <= '0;
      fault_q   <= 1'b0;
      to_cnt    <= '0;
      ld_q      <= 1'b0;
      uns_q     <= 1'b0;
      size_q    <= SZ_B;
      off_q     <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (access) begin
            if (aligned) begin
              bus_req   <= 1'b1;
              bus_we    <= ~mem_rd_M;
              bus_addr  <= {alu_o_M[31:2], 2'b00};
              bus_be    <= be_nxt;
              bus_wdata <= wdata_nxt;
              ld_q      <= mem_rd_M;
              uns_q     <= mem_mask_M[2];
              size_q    <= size;
              off_q     <= off;
              to_cnt    <= '0;
              fault_q   <= 1'b0;
              state     <= REQ;
            end else begin
              rd_q <= '0;
            end
          end
        end
        REQ: begin
          if (bus_ack) begin
            bus_req <= 1'b0;
            fault_q <= bus_err;
            if (ld_q) rd_q <= bus_err ? '0 : ld_ext;
            state   <= DONE;
          end else begin
            to_cnt <= to_cnt_inc;
            if (timeout_hit) begin
              bus_req <= 1'b0;
              fault_q <= 1'b1;
              if (ld_q) rd_q <= '0;
              state   <= DONE;
            end
          end
        end
        DONE: begin
          fault_q <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    stall_M    = ((state == IDLE) && access && aligned) || (state == REQ);
    misalign_M = (state == IDLE) && access && !aligned;
    fault_M    = (state == DONE) && fault_q;
    // A misaligned load returns zero in the same cycle it is flagged.
    rd_data_M  = misalign_M ? '0 : rd_q;
  end

endmodule
